// File: rtl/flags_unit.sv
// Architectural FLAGS register downstream of the ALU.
// Owns the STI/POP SS interrupt shadow and the TF single-step trap.
module flags_unit #(
  parameter logic [15:0] ARITH_MASK = 16'h08D5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] alu_flags,
  input  logic        update_en,
  input  logic [15:0] update_mask,
  input  logic        load_en,
  input  logic        load_low_only,
  input  logic [15:0] load_val,
  input  logic [2:0]  cmd,
  input  logic        shadow_req,
  input  logic        instr_end,
  input  logic        trap_ack,
  output logic [15:0] flags,
  output logic        int_enabled,
  output logic        trap_pending
);

  localparam logic [15:0] WR_MASK = 16'h0FD5;
  localparam logic [15:0] FIXED   = 16'hF002;

  localparam int CF = 0;
  localparam int TF = 8;
  localparam int IF = 9;
  localparam int DF = 10;

  typedef enum logic [2:0] {
    C_NOP = 3'd0,
    C_CLC = 3'd1,
    C_STC = 3'd2,
    C_CLI = 3'd3,
    C_STI = 3'd4,
    C_CLD = 3'd5,
    C_STD = 3'd6,
    C_CLR = 3'd7
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_LAST  = 2'd2
  } shadow_t;

  logic [15:0] arch;
  logic [15:0] upd_m;
  logic [15:0] nxt_raw;
  logic [15:0] nxt;
  cmd_t        op;

  shadow_t state;
  shadow_t state_nxt;
  logic    arm;
  logic    int_nxt;
  logic    tf_armed;
  logic    trap_nxt;

  assign op    = cmd_t'(cmd);
  assign upd_m = update_en ? (update_mask & ARITH_MASK) : 16'h0000;

  always_comb begin
    nxt_raw = arch;
    if (load_en) begin
      if (load_low_only) begin
        nxt_raw[7:0] = load_val[7:0];
      end else begin
        nxt_raw = load_val;
      end
    end else begin
      nxt_raw = (arch & ~upd_m) | (alu_flags & upd_m);
      // cmd is applied last so it beats the ALU on a CF clash
      unique case (op)
        C_CLC: nxt_raw[CF] = 1'b0;
        C_STC: nxt_raw[CF] = 1'b1;
        C_CLI: nxt_raw[IF] = 1'b0;
        C_STI: nxt_raw[IF] = 1'b1;
        C_CLD: nxt_raw[DF] = 1'b0;
        C_STD: nxt_raw[DF] = 1'b1;
        C_CLR: begin
          nxt_raw[TF] = 1'b0;
          nxt_raw[IF] = 1'b0;
        end
        default: ;
      endcase
    end
    nxt = (nxt_raw & WR_MASK) | FIXED;
  end

  always_comb begin
    arm = shadow_req;
    if (!load_en && op == C_STI && !arch[IF]) begin
      arm = 1'b1;
    end
    if (load_en && !load_low_only && !arch[IF] && load_val[IF]) begin
      arm = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = instr_end ? S_LAST : S_ARMED;
    end else if (instr_end) begin
      unique case (state)
        S_ARMED: state_nxt = S_LAST;
        S_LAST:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
    int_nxt = nxt[IF] && (state_nxt == S_IDLE);
  end

  always_comb begin
    trap_nxt = trap_pending;
    if (instr_end && tf_armed) begin
      trap_nxt = 1'b1;
    end else if (trap_ack) begin
      trap_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      arch         <= FIXED;
      state        <= S_IDLE;
      int_enabled  <= 1'b0;
      tf_armed     <= 1'b0;
      trap_pending <= 1'b0;
    end else begin
      arch         <= nxt;
      state        <= state_nxt;
      int_enabled  <= int_nxt;
      trap_pending <= trap_nxt;
      if (instr_end) begin
        tf_armed <= nxt[TF];
      end
    end
  end

  assign flags = arch;

endmodule

// File: tb/tb_flags_unit.sv
// Bench for flags_unit: directed scenarios plus random
// traffic against an instruction-level reference model.
module tb_flags_unit;

  logic        clk;
  logic        reset_n;
  logic [15:0] alu_flags;
  logic        update_en;
  logic [15:0] update_mask;
  logic        load_en;
  logic        load_low_only;
  logic [15:0] load_val;
  logic [2:0]  cmd;
  logic        shadow_req;
  logic        instr_end;
  logic        trap_ack;
  logic [15:0] flags;
  logic        int_enabled;
  logic        trap_pending;

  int n_chk;
  int n_fail;

  logic [15:0] m_flags;
  int          m_rem;
  logic        m_tfa;
  logic        m_trap;
  logic        m_int;

  flags_unit dut (
    .clk(clk),
    .reset_n(reset_n),
    .alu_flags(alu_flags),
    .update_en(update_en),
    .update_mask(update_mask),
    .load_en(load_en),
    .load_low_only(load_low_only),
    .load_val(load_val),
    .cmd(cmd),
    .shadow_req(shadow_req),
    .instr_end(instr_end),
    .trap_ack(trap_ack),
    .flags(flags),
    .int_enabled(int_enabled),
    .trap_pending(trap_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] arch(input logic [15:0] v);
    return (v & 16'h0FD5) | 16'hF002;
  endfunction

  // Reference: flags as a 16-bit view, shadow as a count of
  // instruction ends still to go before interrupts are allowed.
  task automatic model_step();
    logic [15:0] nf;
    logic [15:0] m;
    logic        armev;
    if (!reset_n) begin
      m_flags = 16'hF002;
      m_rem   = 0;
      m_tfa   = 1'b0;
      m_trap  = 1'b0;
      m_int   = 1'b0;
      return;
    end
    nf = m_flags;
    armev = shadow_req;
    if (load_en) begin
      if (load_low_only) nf = {m_flags[15:8], load_val[7:0]};
      else nf = load_val;
      if (!load_low_only && !m_flags[9] && load_val[9]) armev = 1'b1;
    end else begin
      m = update_en ? (update_mask & 16'h08D5) : 16'h0;
      nf = (m_flags & ~m) | (alu_flags & m);
      case (cmd)
        3'd1: nf[0] = 1'b0;
        3'd2: nf[0] = 1'b1;
        3'd3: nf[9] = 1'b0;
        3'd4: begin
          nf[9] = 1'b1;
          if (!m_flags[9]) armev = 1'b1;
        end
        3'd5: nf[10] = 1'b0;
        3'd6: nf[10] = 1'b1;
        3'd7: begin
          nf[8] = 1'b0;
          nf[9] = 1'b0;
        end
        default: ;
      endcase
    end
    nf = arch(nf);
    if (armev) m_rem = instr_end ? 1 : 2;
    else if (instr_end && m_rem > 0) m_rem = m_rem - 1;
    if (instr_end && m_tfa) m_trap = 1'b1;
    else if (trap_ack) m_trap = 1'b0;
    if (instr_end) m_tfa = nf[8];
    m_flags = nf;
    m_int = nf[9] && (m_rem == 0);
  endtask

  task automatic idle();
    reset_n       = 1'b1;
    alu_flags     = 16'h0;
    update_en     = 1'b0;
    update_mask   = 16'h0;
    load_en       = 1'b0;
    load_low_only = 1'b0;
    load_val      = 16'h0;
    cmd           = 3'd0;
    shadow_req    = 1'b0;
    instr_end     = 1'b0;
    trap_ack      = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("flags", flags, m_flags);
    chk("int_enabled", {15'h0, int_enabled}, {15'h0, m_int});
    chk("trap_pending", {15'h0, trap_pending}, {15'h0, m_trap});
    idle();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_flags = 16'hF002;
    m_rem = 0;
    m_tfa = 1'b0;
    m_trap = 1'b0;
    m_int = 1'b0;
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    step();
    chk("reset_flags", flags, 16'hF002);
    chk("reset_int", {15'h0, int_enabled}, 16'h0);
    chk("reset_trap", {15'h0, trap_pending}, 16'h0);

    update_en = 1'b1; update_mask = 16'hFFFF; alu_flags = 16'hFFFF;
    step();
    chk("alu_all", flags, 16'hF8D7);
    update_en = 1'b1; update_mask = 16'h0001; alu_flags = 16'h0;
    step();
    chk("alu_cf", flags, 16'hF8D6);

    update_en = 1'b1; update_mask = 16'h0001; cmd = 3'd2;
    step();
    chk("stc_wins", {15'h0, flags[0]}, 16'h1);
    load_en = 1'b1; load_val = 16'h0; cmd = 3'd6;
    step();
    chk("load_over_cmd", flags, 16'hF002);

    cmd = 3'd4; instr_end = 1'b1;
    step();
    chk("sti_if", {15'h0, flags[9]}, 16'h1);
    chk("sti_shadow", {15'h0, int_enabled}, 16'h0);
    step();
    chk("shadow_hold", {15'h0, int_enabled}, 16'h0);
    instr_end = 1'b1;
    step();
    chk("shadow_done", {15'h0, int_enabled}, 16'h1);
    shadow_req = 1'b1; instr_end = 1'b1;
    step();
    chk("popss_shadow", {15'h0, int_enabled}, 16'h0);
    instr_end = 1'b1;
    step();
    chk("popss_done", {15'h0, int_enabled}, 16'h1);

    load_en = 1'b1; load_val = 16'h0100; instr_end = 1'b1;
    step();
    chk("popf_notrap", {15'h0, trap_pending}, 16'h0);
    instr_end = 1'b1;
    step();
    chk("tf_trap", {15'h0, trap_pending}, 16'h1);
    for (int i = 0; i < 3; i++) step();
    chk("trap_held", {15'h0, trap_pending}, 16'h1);
    trap_ack = 1'b1; cmd = 3'd7;
    step();
    chk("trap_ack", {15'h0, trap_pending}, 16'h0);
    chk("clr_tf_if", flags, 16'hF002);

    cmd = 3'd6;
    step();
    load_en = 1'b1; load_low_only = 1'b1; load_val = 16'hFFFF;
    step();
    chk("sahf", flags, 16'hF4D7);
    load_en = 1'b1; load_val = 16'h0300; instr_end = 1'b1;
    step();
    instr_end = 1'b1;
    step();
    chk("pre_reset_trap", {15'h0, trap_pending}, 16'h1);
    reset_n = 1'b0;
    step();
    chk("rst_flags", flags, 16'hF002);
    chk("rst_trap", {15'h0, trap_pending}, 16'h0);
    chk("rst_int", {15'h0, int_enabled}, 16'h0);

    for (int i = 0; i < 3000; i++) begin
      reset_n       = ($urandom_range(0, 199) != 0);
      alu_flags     = 16'($urandom);
      update_en     = 1'($urandom);
      update_mask   = 16'($urandom);
      load_en       = ($urandom_range(0, 7) == 0);
      load_low_only = 1'($urandom);
      load_val      = 16'($urandom);
      cmd           = 3'($urandom);
      shadow_req    = ($urandom_range(0, 7) == 0);
      instr_end     = ($urandom_range(0, 2) == 0);
      trap_ack      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
